// File: rtl/mem_io_ctrl.sv
`timescale 1ns / 1ps
// mem_io_ctrl: decodes CPU bus requests onto a synchronous on-chip RAM and memory-mapped devices
// (LEDs, synchronized switches, halt-aware cycle timer, status), returning read data one cycle later.
module mem_io_ctrl #(
    parameter int unsigned RAM_AW = 8,
    parameter int unsigned DW     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        mem_cmd,
    input  logic [8:0]        mem_addr,
    input  logic [DW-1:0]     write_data,
    output logic [DW-1:0]     read_data,
    input  logic              halt,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [DW-1:0]     ram_din,
    output logic              ram_we,
    input  logic [DW-1:0]     ram_dout,
    input  logic [7:0]        SW,
    output logic [7:0]        LEDR
);

    localparam logic [1:0] CmdRead  = 2'b01;
    localparam logic [1:0] CmdWrite = 2'b10;

    localparam logic [8:0] AddrLed    = 9'h100;
    localparam logic [8:0] AddrSw     = 9'h140;
    localparam logic [8:0] AddrTimer  = 9'h180;
    localparam logic [8:0] AddrStatus = 9'h181;

    typedef enum logic {
        StRun,
        StHalted
    } state_e;

    state_e        state_q, state_d;
    logic [7:0]    ledr_q, ledr_d;
    logic [7:0]    sw_meta_q, sw_sync_q;
    logic [DW-1:0] timer_q, timer_d;
    logic          bus_err_q, bus_err_d;
    logic          ovf_q, ovf_d;
    logic          sel_ram_q, sel_ram_d;
    logic [DW-1:0] io_q, io_d;

    logic is_rd, is_wr;
    logic hit_ram, hit_led, hit_sw, hit_tmr, hit_sts, unmapped;
    logic running, halted;
    logic err_set, ovf_set;

    assign is_rd = (mem_cmd == CmdRead);
    assign is_wr = (mem_cmd == CmdWrite);

    // RAM occupies the lower half of the 9-bit map.
    assign hit_ram  = ~mem_addr[8];
    assign hit_led  = (mem_addr == AddrLed);
    assign hit_sw   = (mem_addr == AddrSw);
    assign hit_tmr  = (mem_addr == AddrTimer);
    assign hit_sts  = (mem_addr == AddrStatus);
    assign unmapped = ~(hit_ram | hit_led | hit_sw | hit_tmr | hit_sts);

    assign running = (state_q == StRun);
    assign halted  = (state_q == StHalted);

    assign ram_addr  = mem_addr[RAM_AW-1:0];
    assign ram_din   = write_data;
    assign ram_we    = is_wr & hit_ram;
    assign LEDR      = ledr_q;
    assign read_data = sel_ram_q ? ram_dout : io_q;

    // Writes to the read-only switch port count as illegal accesses.
    assign err_set = (is_rd & unmapped) | (is_wr & (hit_sw | unmapped));

    always_comb begin
        state_d   = state_q;
        ledr_d    = ledr_q;
        timer_d   = timer_q;
        bus_err_d = bus_err_q;
        ovf_d     = ovf_q;
        sel_ram_d = sel_ram_q;
        io_d      = io_q;
        ovf_set   = 1'b0;

        unique case (state_q)
            StRun: begin
                if (halt) begin
                    state_d = StHalted;
                end else begin
                    timer_d = timer_q + DW'(1);
                    ovf_set = (timer_q == '1);
                end
            end
            StHalted: begin
                state_d = StHalted;
            end
            default: begin
                state_d = StRun;
            end
        endcase

        if (is_wr) begin
            if (hit_led) begin
                ledr_d = write_data[7:0];
            end
            if (hit_tmr) begin
                timer_d = '0;
            end
            if (hit_sts) begin
                if (write_data[2]) begin
                    bus_err_d = 1'b0;
                end
                if (write_data[3]) begin
                    ovf_d = 1'b0;
                end
            end
        end

        if (err_set) begin
            bus_err_d = 1'b1;
        end
        if (ovf_set) begin
            ovf_d = 1'b1;
        end

        if (is_rd) begin
            sel_ram_d = hit_ram;
            io_d      = '0;
            if (hit_led) begin
                io_d = {{(DW-8){1'b0}}, ledr_q};
            end else if (hit_sw) begin
                io_d = {{(DW-8){1'b0}}, sw_sync_q};
            end else if (hit_tmr) begin
                io_d = timer_q;
            end else if (hit_sts) begin
                io_d = {{(DW-4){1'b0}}, ovf_q, bus_err_q, halted, running};
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StRun;
            ledr_q    <= '0;
            sw_meta_q <= '0;
            sw_sync_q <= '0;
            timer_q   <= '0;
            bus_err_q <= 1'b0;
            ovf_q     <= 1'b0;
            sel_ram_q <= 1'b0;
            io_q      <= '0;
        end else begin
            state_q   <= state_d;
            ledr_q    <= ledr_d;
            sw_meta_q <= SW;
            sw_sync_q <= sw_meta_q;
            timer_q   <= timer_d;
            bus_err_q <= bus_err_d;
            ovf_q     <= ovf_d;
            sel_ram_q <= sel_ram_d;
            io_q      <= io_d;
        end
    end

endmodule
